// File: rtl/vld_dly_line.sv
// Valid-tagged, stallable, multi-channel delay line with runtime-selectable delay (1..MAX_DLY).
// Optional VLD_DLY_OCC_EN exposes the in-flight sample count on port occ.
module vld_dly_line #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_CH     = 1,
  parameter int MAX_DLY    = 4,
  parameter int DLY_W      = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic                         flush,
  input  logic [DLY_W-1:0]             dly_sel,
  input  logic                         din_vld,
  input  logic [NUM_CH*DATA_WIDTH-1:0] din,
  output logic                         dout_vld,
  output logic [NUM_CH*DATA_WIDTH-1:0] dout,
  output logic                         cfg_pend,
  output logic                         cfg_err
`ifdef VLD_DLY_OCC_EN
  ,
  output logic [DLY_W-1:0]             occ
`endif
);

  localparam int                DW      = NUM_CH * DATA_WIDTH;
  localparam logic [DLY_W-1:0]  SEL_MAX = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0]  SEL_ONE = DLY_W'(1'b1);
  localparam logic [DLY_W-1:0]  SEL_ZRO = {DLY_W{1'b0}};

  // Index 0 is stage 1; index MAX_DLY-1 is the deepest stage.
  logic [DW-1:0]      stage_data_r [MAX_DLY];
  logic [MAX_DLY-1:0] stage_vld_r;
  logic [DLY_W-1:0]   dly_r;
  logic [DLY_W-1:0]   cnt_r;
  logic               cfg_err_r;

  logic [DLY_W-1:0]   sel_c_s;
  logic [DLY_W-1:0]   cnt_nxt_s;
  logic [DW-1:0]      out_data_s;
  logic               out_vld_s;
  logic               sel_bad_s;

  // Clamp the requested delay into the legal range.
  always_comb begin
    sel_c_s   = dly_sel;
    sel_bad_s = 1'b0;
    if (dly_sel == SEL_ZRO) begin
      sel_c_s   = SEL_ONE;
      sel_bad_s = 1'b1;
    end else if (dly_sel > SEL_MAX) begin
      sel_c_s   = SEL_MAX;
      sel_bad_s = 1'b1;
    end else begin
      sel_c_s   = dly_sel;
      sel_bad_s = 1'b0;
    end
  end

  // Output tap: select stage dly_r directly from the stage registers.
  always_comb begin
    out_data_s = stage_data_r[0];
    out_vld_s  = stage_vld_r[0];
    for (int k = 0; k < MAX_DLY; k++) begin
      if (dly_r == DLY_W'(k + 1)) begin
        out_data_s = stage_data_r[k];
        out_vld_s  = stage_vld_r[k];
      end else begin
        out_data_s = out_data_s;
        out_vld_s  = out_vld_s;
      end
    end
  end

  // Occupancy next-state: flush clears, otherwise track entries and exits on advance.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = SEL_ZRO;
    end else if (en) begin
      case ({din_vld, out_vld_s})
        2'b10:   cnt_nxt_s = cnt_r + SEL_ONE;
        2'b01:   cnt_nxt_s = cnt_r - SEL_ONE;
        default: cnt_nxt_s = cnt_r;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Stage shift register; valid tags beyond the active delay are cleared as the line advances.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < MAX_DLY; k++) begin
        stage_data_r[k] <= {DW{1'b0}};
      end
      stage_vld_r <= {MAX_DLY{1'b0}};
    end else if (flush) begin
      stage_vld_r <= {MAX_DLY{1'b0}};
    end else if (en) begin
      stage_data_r[0] <= din;
      stage_vld_r[0]  <= din_vld;
      for (int k = 1; k < MAX_DLY; k++) begin
        stage_data_r[k] <= stage_data_r[k-1];
        stage_vld_r[k]  <= (DLY_W'(k + 1) <= dly_r) ? stage_vld_r[k-1] : 1'b0;
      end
    end
  end

  // Control state: occupancy, active delay (only reloaded while the line is empty), config error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r     <= SEL_ZRO;
      dly_r     <= SEL_ONE;
      cfg_err_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      cfg_err_r <= sel_bad_s;
      if (cnt_r == SEL_ZRO) begin
        dly_r <= sel_c_s;
      end else begin
        dly_r <= dly_r;
      end
    end
  end

  assign dout     = out_data_s;
  assign dout_vld = out_vld_s;
  assign cfg_err  = cfg_err_r;
  assign cfg_pend = (cnt_r != SEL_ZRO) && (sel_c_s != dly_r);
`ifdef VLD_DLY_OCC_EN
  assign occ      = cnt_r;
`endif

endmodule

// File: tb/tb_vld_dly_line.sv
// Directed self-checking bench for vld_dly_line (two channels, MAX_DLY=4).
module tb_vld_dly_line;

  localparam int DWD  = 18;
  localparam int NCH  = 2;
  localparam int MAXD = 4;
  localparam int DLW  = 3;

  logic                clk = 1'b0;
  logic                rstn;
  logic                en;
  logic                flush;
  logic [DLW-1:0]      dly_sel;
  logic                din_vld;
  logic [NCH*DWD-1:0]  din;
  logic                dout_vld;
  logic [NCH*DWD-1:0]  dout;
  logic                cfg_pend;
  logic                cfg_err;
`ifdef VLD_DLY_OCC_EN
  logic [DLW-1:0]      occ;
`endif

  int n_vec = 0;
  int n_err = 0;

  vld_dly_line #(.DATA_WIDTH(DWD), .NUM_CH(NCH), .MAX_DLY(MAXD), .DLY_W(DLW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .flush(flush), .dly_sel(dly_sel),
    .din_vld(din_vld), .din(din), .dout_vld(dout_vld), .dout(dout),
    .cfg_pend(cfg_pend), .cfg_err(cfg_err)
`ifdef VLD_DLY_OCC_EN
    , .occ(occ)
`endif
  );

  always #5 clk = ~clk;

  // Channel 1 carries the bitwise complement of channel 0 so lane packing is exercised.
  function automatic logic [NCH*DWD-1:0] pk(input logic [DWD-1:0] v);
    return {v ^ 18'h3FFFF, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic exp_vld, input logic [DWD-1:0] exp_val);
    chk({tag, "_vld"}, 64'(dout_vld), 64'(exp_vld));
    if (exp_vld) chk({tag, "_dout"}, 64'(dout), 64'(pk(exp_val)));
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; flush = 1'b0; dly_sel = 3'd1; din_vld = 1'b0; din = pk(18'd0);
    #1;
    chk("rst_vld", 64'(dout_vld), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_cfg_pend", 64'(cfg_pend), 64'd0);
`ifdef VLD_DLY_OCC_EN
    chk("rst_occ", 64'(occ), 64'd0);
`endif
    #20 rstn = 1'b1;

    // Single sample at delay 3.
    dly_sel = 3'd3; en = 1'b1;
    tick(); chk_out("a_e1", 1'b0, 18'd0);
    din = pk(18'h2A5); din_vld = 1'b1;
    tick(); chk_out("a_e2", 1'b0, 18'd0);
    din_vld = 1'b0;
    tick(); chk_out("a_e3", 1'b0, 18'd0);
    tick(); chk_out("a_e4", 1'b1, 18'h2A5);
    tick(); chk_out("a_e5", 1'b0, 18'd0);
    chk("a_cfg_err", 64'(cfg_err), 64'd0);

    // Continuous stream at MAX_DLY.
    dly_sel = 3'd4;
    for (int j = 1; j <= 8; j++) begin
      din = pk(18'(j)); din_vld = 1'b1;
      tick();
      chk_out("stream", j >= 4, 18'(j - 3));
      chk("stream_pend", 64'(cfg_pend), 64'd0);
`ifdef VLD_DLY_OCC_EN
      chk("stream_occ", 64'(occ), 64'((j < 4) ? j : 4));
`endif
    end

    // Two stall cycles: output holds, input ignored.
    en = 1'b0; din = pk(18'd99);
    for (int s = 0; s < 2; s++) begin
      tick(); chk_out("stall", 1'b1, 18'd5);
    end
    en = 1'b1;
    for (int j = 9; j <= 12; j++) begin
      din = pk(18'(j)); din_vld = 1'b1;
      tick(); chk_out("resume", 1'b1, 18'(j - 3));
    end
    din_vld = 1'b0;
    for (int j = 13; j <= 16; j++) begin
      tick(); chk_out("drain", j <= 15, 18'(j - 3));
    end
`ifdef VLD_DLY_OCC_EN
    chk("drain_occ", 64'(occ), 64'd0);
`endif

    // Delay change with two samples in flight at delay 2.
    dly_sel = 3'd2;
    tick();
    din = pk(18'h11); din_vld = 1'b1;
    tick(); chk_out("c1", 1'b0, 18'd0);
    din = pk(18'h22); dly_sel = 3'd4;
    #1 chk("c1_pend", 64'(cfg_pend), 64'd1);
    tick(); chk_out("c2", 1'b1, 18'h11);
    chk("c2_pend", 64'(cfg_pend), 64'd1);
    din_vld = 1'b0;
    tick(); chk_out("c3", 1'b1, 18'h22);
    chk("c3_pend", 64'(cfg_pend), 64'd1);
    tick(); chk_out("c4", 1'b0, 18'd0);
    chk("c4_pend", 64'(cfg_pend), 64'd0);
    din = pk(18'h33); din_vld = 1'b1;
    tick(); chk_out("c5", 1'b0, 18'd0);
    din_vld = 1'b0;
    tick(); chk_out("c6", 1'b0, 18'd0);
    tick(); chk_out("c7", 1'b0, 18'd0);
    tick(); chk_out("c8", 1'b1, 18'h33);
    chk("c8_pend", 64'(cfg_pend), 64'd0);
    tick(); chk_out("c9", 1'b0, 18'd0);

    // Flush with three samples in flight; sample on the flush cycle is discarded.
    for (int f = 1; f <= 3; f++) begin
      din = pk(18'(8'h30 + f)); din_vld = 1'b1;
      tick(); chk_out("f_fill", 1'b0, 18'd0);
    end
    flush = 1'b1; din = pk(18'h44);
    tick(); chk_out("f_flush", 1'b0, 18'd0);
    chk("f_pend", 64'(cfg_pend), 64'd0);
`ifdef VLD_DLY_OCC_EN
    chk("f_occ", 64'(occ), 64'd0);
`endif
    flush = 1'b0; din_vld = 1'b0;
    for (int f = 0; f < 5; f++) begin
      tick(); chk_out("f_after", 1'b0, 18'd0);
    end

    // Out-of-range selects clamp and flag an error.
    dly_sel = 3'd0; din = pk(18'h55); din_vld = 1'b1;
    tick(); chk_out("sel0", 1'b1, 18'h55);
    chk("sel0_err", 64'(cfg_err), 64'd1);
    din_vld = 1'b0;
    tick(); chk_out("sel0_drain", 1'b0, 18'd0);
    dly_sel = 3'd7; din = pk(18'h77); din_vld = 1'b1;
    tick(); chk_out("sel7_g1", 1'b0, 18'd0);
    chk("sel7_err", 64'(cfg_err), 64'd1);
    din_vld = 1'b0;
    tick(); chk_out("sel7_g2", 1'b0, 18'd0);
    tick(); chk_out("sel7_g3", 1'b0, 18'd0);
    tick(); chk_out("sel7_g4", 1'b1, 18'h77);
    dly_sel = 3'd3;
    tick(); chk("sel3_err", 64'(cfg_err), 64'd0);
    chk_out("sel3_g5", 1'b0, 18'd0);

    // Asynchronous reset mid-stream.
    dly_sel = 3'd0; din = pk(18'h66); din_vld = 1'b1;
    tick(); chk_out("ar_pre1", 1'b1, 18'h66);
    din = pk(18'h67);
    tick(); chk_out("ar_pre2", 1'b1, 18'h67);
    chk("ar_pre_err", 64'(cfg_err), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar_vld", 64'(dout_vld), 64'd0);
    chk("ar_dout", 64'(dout), 64'd0);
    chk("ar_err", 64'(cfg_err), 64'd0);
    chk("ar_pend", 64'(cfg_pend), 64'd0);
    #1 rstn = 1'b1;
    dly_sel = 3'd2; din = pk(18'h88); din_vld = 1'b1;
    tick(); chk_out("ar_post1", 1'b0, 18'd0);
    din_vld = 1'b0;
    tick(); chk_out("ar_post2", 1'b1, 18'h88);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
